// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states and default sizing.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

  localparam int unsigned DEF_MEM_WORDS = 64;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// on contention the port that did not win last time is chosen.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  // Select the winner from the current requests and the previous grant
  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_id_o    = 1'b0;
    if (req0_i && req1_i) begin
      grant_id_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_id_o = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port word-addressed data
// memory. Each accepted request runs IDLE -> ACCESS -> RESP, driving the
// memory in ACCESS and returning a one-cycle ack in RESP.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

  dmem_state_e       state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic              latch_en;
  logic              arb_valid, arb_id;
  logic              we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_err;
  logic              in_resp;

  rr_arb2 u_rr_arb2 (
    .req0_i        (p0_req),
    .req1_i        (p1_req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (arb_valid),
    .grant_id_o    (arb_id)
  );

  // Mux the winning port's fields and classify its address
  always_comb begin
    sel_we    = arb_id ? p1_we    : p0_we;
    sel_addr  = arb_id ? p1_addr  : p0_addr;
    sel_wdata = arb_id ? p1_wdata : p0_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[ADDR_W-1:2] >= WORD_LIMIT);
  end

  // Next-state and grant bookkeeping; requests are only looked at in IDLE
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    latch_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d      = ST_ACCESS;
          last_grant_d = arb_id;
          grant_id_d   = arb_id;
          latch_en     = 1'b1;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; last_grant resets to 1 so port 0 wins the first contention
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
    end
  end

  // Request latches and read capture; addr/wdata double as the held memory bus
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (latch_en) begin
        we_q    <= sel_we;
        err_q   <= sel_err;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == ST_ACCESS) begin
        rdata_q <= (!we_q && !err_q) ? mem_rdata : '0;
      end
    end
  end

  // Memory drive and per-port responses; reset gates the write combinationally
  always_comb begin
    in_resp   = (state_q == ST_RESP);
    mem_we    = (state_q == ST_ACCESS) && we_q && !err_q && !reset;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    busy      = (state_q != ST_IDLE);
    grant_id  = grant_id_q;
    p0_ack    = in_resp && !grant_id_q;
    p0_err    = in_resp && !grant_id_q && err_q;
    p0_rdata  = (in_resp && !grant_id_q) ? rdata_q : '0;
    p1_ack    = in_resp && grant_id_q;
    p1_err    = in_resp && grant_id_q && err_q;
    p1_rdata  = (in_resp && grant_id_q) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, grant_id;
  logic        mem_init;
  logic [31:0] mem [64];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_WORDS(64), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  // Data memory: combinational read, write on posedge; word i preloads to A000_0000+i
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; mem_init = 1;
    tick(); tick();
    mem_init = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL rst_grant got=%0b exp=0", grant_id); end
    total++; if ({p0_ack, p0_err, p1_ack, p1_err} !== 4'b0) begin bad++; $display("FAIL rst_ackerr got=%b exp=0000", {p0_ack, p0_err, p1_ack, p1_err}); end
    total++; if ({p0_rdata, p1_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", {p0_rdata, p1_rdata}); end
    total++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin bad++; $display("FAIL rst_mem got=%h exp=0", {mem_we, mem_addr, mem_wdata}); end
    reset = 0;
    tick();
  endtask

  task automatic test_store_load();
    p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
    tick();
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL st_we got=%0b exp=1", mem_we); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL st_addr got=%h exp=00000010", mem_addr); end
    total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL st_wdata got=%h exp=deadbeef", mem_wdata); end
    total++; if (busy !== 1'b1 || grant_id !== 1'b0) begin bad++; $display("FAIL st_busy busy=%0b grant=%0b exp=1,0", busy, grant_id); end
    tick();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL st_we_once got=%0b exp=0", mem_we); end
    total++; if ({p0_ack, p0_err, p1_ack} !== 3'b100) begin bad++; $display("FAIL st_ack got=%b exp=100", {p0_ack, p0_err, p1_ack}); end
    total++; if (p0_rdata !== 32'h0) begin bad++; $display("FAIL st_rdata got=%h exp=0", p0_rdata); end
    p0_req = 0;
    tick();
    total++; if (busy !== 1'b0 || p0_ack !== 1'b0) begin bad++; $display("FAIL st_idle busy=%0b ack=%0b exp=0,0", busy, p0_ack); end
    p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_wdata = 32'h0;
    tick();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL ld_we got=%0b exp=0", mem_we); end
    tick();
    total++; if (p0_ack !== 1'b1 || p0_err !== 1'b0) begin bad++; $display("FAIL ld_ack ack=%0b err=%0b exp=1,0", p0_ack, p0_err); end
    total++; if (p0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", p0_rdata); end
    p0_req = 0;
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] exp_rd;
    logic        exp_id;
    reset = 1; tick(); reset = 0; tick();
    p0_req = 1; p0_we = 0; p0_addr = 32'h0;
    p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      exp_id = k[0];
      exp_rd = exp_id ? 32'hA000_0001 : 32'hA000_0000;
      tick();
      total++; if (grant_id !== exp_id || busy !== 1'b1) begin bad++; $display("FAIL rr_grant%0d grant=%0b busy=%0b exp=%0b,1", k, grant_id, busy, exp_id); end
      tick();
      total++; if ({p0_ack, p1_ack} !== (exp_id ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_ack%0d got=%b exp=%b", k, {p0_ack, p1_ack}, exp_id ? 2'b01 : 2'b10); end
      total++; if ((exp_id ? p1_rdata : p0_rdata) !== exp_rd) begin bad++; $display("FAIL rr_rdata%0d got=%h exp=%h", k, exp_id ? p1_rdata : p0_rdata, exp_rd); end
      total++; if ((exp_id ? p0_rdata : p1_rdata) !== 32'h0) begin bad++; $display("FAIL rr_other%0d got=%h exp=0", k, exp_id ? p0_rdata : p1_rdata); end
      if (k == 3) begin p0_req = 0; p1_req = 0; end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle%0d got=%0b exp=0", k, busy); end
    end
  endtask

  task automatic test_out_of_range();
    p1_req = 1; p1_we = 1; p1_addr = 32'h100; p1_wdata = 32'h12345678;
    tick();
    total++; if (mem_we !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL oor_we we=%0b busy=%0b exp=0,1", mem_we, busy); end
    tick();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL oor_we2 got=%0b exp=0", mem_we); end
    total++; if ({p1_ack, p1_err, p0_ack} !== 3'b110) begin bad++; $display("FAIL oor_ack got=%b exp=110", {p1_ack, p1_err, p0_ack}); end
    total++; if (p1_rdata !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", p1_rdata); end
    p1_req = 0;
    tick();
    p0_req = 1; p0_we = 0; p0_addr = 32'h0;
    tick(); tick();
    total++; if (p0_ack !== 1'b1 || p0_rdata !== 32'hA000_0000) begin bad++; $display("FAIL oor_word0 ack=%0b rdata=%h exp=1,a0000000", p0_ack, p0_rdata); end
    p0_req = 0;
    tick();
  endtask

  task automatic test_misaligned();
    p0_req = 1; p0_we = 0; p0_addr = 32'h6;
    tick();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mis_we got=%0b exp=0", mem_we); end
    tick();
    total++; if ({p0_ack, p0_err} !== 2'b11) begin bad++; $display("FAIL mis_ack got=%b exp=11", {p0_ack, p0_err}); end
    total++; if (p0_rdata !== 32'h0) begin bad++; $display("FAIL mis_rdata got=%h exp=0", p0_rdata); end
    p0_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'hCAFEF00D;
    tick();
    reset = 1; p0_req = 0;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rm_we got=%0b exp=0", mem_we); end
    tick();
    total++; if (busy !== 1'b0 || {p0_ack, p1_ack} !== 2'b00) begin bad++; $display("FAIL rm_clear busy=%0b acks=%b exp=0,00", busy, {p0_ack, p1_ack}); end
    reset = 0;
    tick();
    total++; if (p0_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_noack ack=%0b busy=%0b exp=0,0", p0_ack, busy); end
    p0_req = 1; p0_we = 0; p0_addr = 32'h20; p0_wdata = 32'h0;
    tick(); tick();
    total++; if (p0_ack !== 1'b1 || p0_rdata !== 32'hA000_0008) begin bad++; $display("FAIL rm_keep ack=%0b rdata=%h exp=1,a0000008", p0_ack, p0_rdata); end
    p0_req = 0;
    tick();
  endtask

  task automatic test_drop();
    p1_req = 1; p1_we = 0; p1_addr = 32'h8;
    tick();
    p1_req = 0;
    total++; if (busy !== 1'b1 || grant_id !== 1'b1) begin bad++; $display("FAIL drop_grant busy=%0b grant=%0b exp=1,1", busy, grant_id); end
    tick();
    total++; if (p1_ack !== 1'b1 || p1_rdata !== 32'hA000_0002) begin bad++; $display("FAIL drop_ack ack=%0b rdata=%h exp=1,a0000002", p1_ack, p1_rdata); end
    tick();
    tick();
    total++; if (busy !== 1'b0 || p1_ack !== 1'b0) begin bad++; $display("FAIL drop_nonew busy=%0b ack=%0b exp=0,0", busy, p1_ack); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_contention();
    test_out_of_range();
    test_misaligned();
    test_reset_mid();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
